fft_frame_feeder: RTL
=====================

# fft_frame_feeder

Input-side driver for the low-power serial FFT. The block accepts real samples from an upstream valid/ready source and stores them in a double-buffered 8-entry frame store. For each complete frame it produces the FFT's load protocol: 8 consecutive `vld_in` beats, a programmable idle gap, then a one-cycle `start` pulse. It sits directly in front of `low_power_fft`; its outputs drive that block's `vld_in`, `in` and `start` ports one-to-one.

## Interface
- `width`, 9, sample width in bits; must match the FFT `width`.
- `N`, 8, samples per frame; fixed at 8 for this FFT.
- `GAP`, 2, idle cycles between the last `vld_in` beat and `start`; legal range 0..15.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rstn`  input  1  reset; one clock, asynchronous assert, active-low.
- `s_valid`  input  1  upstream sample valid.
- `s_data`  input  width  upstream sample.
- `s_ready`  output  1  block can accept a sample this cycle.
- `fft_vld_in`  output  1  drives FFT `vld_in`.
- `fft_in`  output  width  drives FFT `in`.
- `fft_start`  output  1  drives FFT `start`; one-cycle pulse.
- `busy`  output  1  high in any state other than IDLE.
- `frame_cnt`  output  8  frames launched; increments on each `fft_start`; wraps 255→0.

## Operation
- **Storage**
  - Two banks, each holding N×width bits, with flags `full[1:0]`.
  - Write pointer: `wr_bank` plus 3-bit `wr_idx`. Read pointer: `rd_bank` plus 3-bit `rd_idx`.
- **Fill side**
  - `s_ready = !full[wr_bank]`. This is a registered-flag function only and has no combinational path from `s_valid`.
  - An accept happens when `s_valid && s_ready`: write `s_data` to `bank[wr_bank][wr_idx]`, then increment `wr_idx`.
  - On the accept with `wr_idx==7`:
    - set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_idx` to 0.
- **Drain FSM**
  - IDLE → SEND when `full[rd_bank]` is set.
  - SEND: lasts N cycles.
    - Each cycle `fft_vld_in=1` and `fft_in=bank[rd_bank][rd_idx]`, then `rd_idx` increments.
    - After `rd_idx==7` the FSM goes to GAP, or directly to START if GAP=0.
  - GAP: lasts GAP cycles with `fft_vld_in=0`; then START.
  - START: one cycle with `fft_start=1` and `frame_cnt` incremented.
    - Clear `full[rd_bank]` and toggle `rd_bank`.
    - Next state is SEND if the other bank is already full, otherwise IDLE.
- **Ordering**
  - Samples leave in arrival order.
  - Frames leave in fill order; no frame is reordered, dropped or duplicated.
- **Simultaneous events**
  - The fill-bank flag can be set and the drain-bank flag cleared in the same cycle. These are always different banks, so both updates take effect.
- **Output registration**
  - All outputs are registered except `s_ready`.
  - While not in SEND, `fft_in` holds 0.
- **Reset** (async, any time, including mid-fill or mid-SEND)
  - State = IDLE; flags, pointers and `frame_cnt` cleared.
  - `s_ready=1` (after reset the flags are 0); `fft_vld_in=0`, `fft_in=0`, `fft_start=0`, `busy=0`.
  - Partial and queued frames are discarded; bank contents need not be cleared.

## Timing
- **Fill to launch:** the 8th accept at rising edge t sets `full`. `fft_vld_in` first goes high in the cycle after edge t+1 (IDLE→SEND transition at t+1).
- **Frame length:** N + GAP + 1 cycles, which is 11 with defaults. Pattern: 8 cycles `vld_in`=1, 2 cycles idle, 1 cycle `start`.
- **Back-to-back frames:** with the other bank full at START, the next SEND begins the cycle after `fft_start`. Sustained throughput is 8 samples per 11 cycles.
- **Backpressure:** with both banks full, `s_ready`=0. It rises the cycle after the START cycle, once the freed flag is visible.
- **Overlap:** upstream may fill one bank while the other drains, with no stall as long as the fill completes before the drain finishes.

## Test plan
- **Constant frame:** reset, then 8 accepts of `s_data`=1 with GAP=2.
  - Required: `fft_vld_in` high for exactly 8 cycles with `fft_in`=1 each.
  - Then 2 cycles low, then `fft_start` for 1 cycle; `frame_cnt` 0→1; `busy` falls after START.
- **Ordering:** 1, 2, 4, 8, 16, 32, 64, 128 queued behind the all-ones frame.
  - Required: the second frame's SEND starts the cycle after the first `fft_start`.
  - `fft_in` sequence is 1, 2, 4, …, 128 exactly; `frame_cnt`=2 after the second start.
- **Backpressure:** continuous `s_valid` with values 0..23.
  - Required: `s_ready` drops after 16 accepts and re-rises the cycle after the first `fft_start`.
  - All 24 values emerge in order across 3 frames; none lost or repeated.
- **Reset mid-SEND:** `rstn` low at the 4th `vld_in` beat.
  - Required: outputs are 0 asynchronously, before the next edge, with `s_ready`=1.
  - A fresh frame of 5s afterward is emitted cleanly, with no stale samples.
- **GAP=0:** rerun the constant-frame test with GAP=0.
  - Required: `fft_start` is asserted in the cycle immediately after the 8th `vld_in` beat.
- **Wrap:** launch 256 frames.
  - Required: `frame_cnt` reads 255 then 0.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - double-buffered 8-sample frame store driving the serial FFT load protocol
module fft_frame_feeder #(
  parameter int width = 9,
  parameter int N     = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [width-1:0] s_data,
  output logic             s_ready,
  output logic             fft_vld_in,
  output logic [width-1:0] fft_in,
  output logic             fft_start,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, START} state_t;

  state_t           state;
  logic [width-1:0] mem [0:2*N-1];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [3:0]       gap_cnt;
  logic             accept;
  logic             fill_done;
  logic             drain_done;

  // Ready depends only on the registered flags, so there is no path from s_valid
  assign s_ready    = !full[wr_bank];
  assign accept     = s_valid && s_ready;
  assign fill_done  = accept && (wr_idx == LAST_IDX);
  assign drain_done = (state == START);

  // Sample storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wr_bank, wr_idx}] <= s_data;
    end
  end

  // Fill pointer: advance per accept, hop to the other bank after the last slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (accept) begin
      wr_idx <= fill_done ? '0 : wr_idx + 1'b1;
      if (fill_done) begin
        wr_bank <= !wr_bank;
      end
    end
  end

  // Bank-full flags; the fill side and drain side always touch different banks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= '0;
    end else begin
      if (fill_done) begin
        full[wr_bank] <= 1'b1;
      end
      if (drain_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Drain sequencer: N beats out of one bank, GAP idle cycles, then a start pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      gap_cnt    <= '0;
      fft_vld_in <= 1'b0;
      fft_in     <= '0;
      fft_start  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state      <= SEND;
            busy       <= 1'b1;
            fft_vld_in <= 1'b1;
            fft_in     <= mem[{rd_bank, rd_idx}];
            rd_idx     <= rd_idx + 1'b1;
          end
        end
        SEND: begin
          // rd_idx wraps back to zero once every slot of the bank has been shown
          if (rd_idx != '0) begin
            fft_in <= mem[{rd_bank, rd_idx}];
            rd_idx <= rd_idx + 1'b1;
          end else begin
            fft_vld_in <= 1'b0;
            fft_in     <= '0;
            if (GAP == 0) begin
              state     <= START;
              fft_start <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              state   <= GAP_WAIT;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == '0) begin
            state     <= START;
            fft_start <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        START: begin
          fft_start <= 1'b0;
          rd_bank   <= !rd_bank;
          // Chain straight into the next frame when the other bank is already waiting
          if (full[!rd_bank]) begin
            state      <= SEND;
            fft_vld_in <= 1'b1;
            fft_in     <= mem[{!rd_bank, rd_idx}];
            rd_idx     <= rd_idx + 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
